// File: rtl/batcharger_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module   : batcharger_ctrl_p
//  Purpose  : Second-generation battery charger sequencer. Walks the battery
//             through trickle (TC), constant-current (CC) and constant-voltage
//             (CV) charging from ADC samples. It also provides a prescaled
//             charge timer, a temperature pause/resume, over-voltage fault
//             latching and recharge hysteresis. All outputs are registered
//             Moore decodes of the state register.
//  Ports    : clk_i        - state machine clock
//             rstz_i       - asynchronous active-high reset
//             en_i         - module enable
//             vtok_i       - ADC samples valid this cycle
//             vbat_i/ibat_i/tbat_i          - voltage/current/temp samples
//             vcutoff_i/vpreset_i           - TC->CC and CC->CV voltage levels
//             tempmin_i/tempmax_i           - valid temperature window (exclusive)
//             iend_i       - end-of-charge current level
//             tmax_i       - charge time limit in timer ticks (0 = disabled)
//             tc_o/cc_o/cv_o                - analog mode selects
//             imonen_o/vmonen_o/tmonen_o    - monitor enables
//             done_o/timeout_o/fault_o      - status
//             state_o      - current state code
//  Revision : 1.0 - initial release
// ============================================================================
module batcharger_ctrl_p #(
  parameter int unsigned  W        = 8,
  parameter int unsigned  DIV_BITS = 8,
  parameter int unsigned  TMR_W    = 8,
  parameter logic [W-1:0] VMAX     = 8'hD6,
  parameter logic [W-1:0] VHYST    = 8'd5
) (
  input  logic             clk_i,
  input  logic             rstz_i,
  input  logic             en_i,
  input  logic             vtok_i,
  input  logic [W-1:0]     vbat_i,
  input  logic [W-1:0]     ibat_i,
  input  logic [W-1:0]     tbat_i,
  input  logic [W-1:0]     vcutoff_i,
  input  logic [W-1:0]     vpreset_i,
  input  logic [W-1:0]     tempmin_i,
  input  logic [W-1:0]     tempmax_i,
  input  logic [W-1:0]     iend_i,
  input  logic [TMR_W-1:0] tmax_i,
  output logic             tc_o,
  output logic             cc_o,
  output logic             cv_o,
  output logic             imonen_o,
  output logic             vmonen_o,
  output logic             tmonen_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             fault_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_TC    = 3'd2,
    S_CC    = 3'd3,
    S_CV    = 3'd4,
    S_PAUSE = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  state_e              resume_q, resume_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                timeout_q, timeout_d;
  logic [8:0]          outs_q, outs_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             charging;
  logic             tick;
  logic             temp_ok;
  logic             over_v;
  logic             tmr_expired;
  logic             to_entry;
  logic [TMR_W-1:0] timer_inc;
  logic [W-1:0]     recharge_lvl;

  assign charging = (state_q == S_TC) || (state_q == S_CC) || (state_q == S_CV);

  // A timer tick is the prescaler wrapping from all-ones back to zero.
  assign tick = charging && (&presc_q);

  assign temp_ok = (tbat_i > tempmin_i) && (tbat_i < tempmax_i);
  assign over_v  = vbat_i > VMAX;

  // Recharge level vpreset - VHYST, clamped at zero instead of wrapping.
  assign recharge_lvl = (vpreset_i > VHYST) ? (vpreset_i - VHYST) : '0;

  // Timer value after this edge; saturates at all-ones.
  assign timer_inc = (tick && !(&timer_q)) ? (timer_q + TMR_W'(1)) : timer_q;

  // The limit is checked against the post-tick value so that the tick that
  // reaches tmax moves the FSM to DONE on that same edge.
  assign tmr_expired = charging && (tmax_i != '0) && (timer_inc >= tmax_i);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    to_entry = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
    end else if (vtok_i && over_v &&
                 (charging || (state_q == S_PAUSE))) begin
      state_d = S_FAULT;
    end else if (tmr_expired) begin
      state_d  = S_DONE;
      to_entry = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (vtok_i && temp_ok) state_d = S_TC;
        end
        S_TC, S_CC, S_CV: begin
          if (vtok_i) begin
            if (!temp_ok) begin
              // Remember where to resume once the temperature recovers.
              state_d  = S_PAUSE;
              resume_d = state_q;
            end else begin
              case (state_q)
                S_TC:    if (vbat_i >  vcutoff_i) state_d = S_CC;
                S_CC:    if (vbat_i >= vpreset_i) state_d = S_CV;
                default: if (ibat_i <  iend_i)    state_d = S_DONE;
              endcase
            end
          end
        end
        S_PAUSE: begin
          if (vtok_i && temp_ok) state_d = resume_q;
        end
        S_DONE: begin
          if (vtok_i) begin
            if (vbat_i < vcutoff_i)         state_d = S_TC;
            else if (vbat_i < recharge_lvl) state_d = S_CC;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler / timer / timeout flag next values
  // --------------------------------------------------------------------------
  always_comb begin
    presc_d = '0;
    if (charging) begin
      presc_d = presc_q + DIV_BITS'(1);
    end else if (state_q == S_PAUSE) begin
      presc_d = presc_q;
    end
  end

  always_comb begin
    // Clearing whenever the next state is IDLE/WAIT/DONE covers the entry
    // edge; in those states the timer would stay at zero anyway. PAUSE and
    // FAULT see no ticks, so timer_inc equals timer_q there.
    timer_d = timer_inc;
    if ((state_d == S_IDLE) || (state_d == S_WAIT) || (state_d == S_DONE)) begin
      timer_d = '0;
    end
  end

  assign timeout_d = (state_d == S_DONE) &&
                     (to_entry || ((state_q == S_DONE) && timeout_q));

  // --------------------------------------------------------------------------
  // Moore output decode of the next state, registered alongside state_q
  // Bit order: {tc, cc, cv, imonen, vmonen, tmonen, done, timeout, fault}
  // --------------------------------------------------------------------------
  always_comb begin
    outs_d = '0;
    case (state_d)
      S_WAIT:  outs_d = 9'b000_001_000;
      S_TC:    outs_d = 9'b100_011_000;
      S_CC:    outs_d = 9'b010_011_000;
      S_CV:    outs_d = 9'b001_111_000;
      S_PAUSE: outs_d = 9'b000_011_000;
      S_DONE:  outs_d = {7'b000_011_1, timeout_d, 1'b0};
      S_FAULT: outs_d = 9'b000_000_001;
      default: outs_d = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rstz_i) begin
    if (rstz_i) begin
      state_q   <= S_IDLE;
      resume_q  <= S_IDLE;
      presc_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      outs_q    <= '0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      outs_q    <= outs_d;
    end
  end

  assign {tc_o, cc_o, cv_o, imonen_o, vmonen_o, tmonen_o,
          done_o, timeout_o, fault_o} = outs_q;
  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_batcharger_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_batcharger_ctrl_p
//  Purpose  : Self-checking bench for batcharger_ctrl_p (DIV_BITS=2 so that a
//             timer tick is 4 clk cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_batcharger_ctrl_p;

  localparam logic [8:0] O_IDLE    = 9'b000_000_000;
  localparam logic [8:0] O_WAIT    = 9'b000_001_000;
  localparam logic [8:0] O_TC      = 9'b100_011_000;
  localparam logic [8:0] O_CC      = 9'b010_011_000;
  localparam logic [8:0] O_CV      = 9'b001_111_000;
  localparam logic [8:0] O_PAUSE   = 9'b000_011_000;
  localparam logic [8:0] O_DONE    = 9'b000_011_100;
  localparam logic [8:0] O_DONE_TO = 9'b000_011_110;
  localparam logic [8:0] O_FAULT   = 9'b000_000_001;

  logic       clk = 1'b0;
  logic       rstz, en, vtok;
  logic [7:0] vbat, ibat, tbat, vcutoff, vpreset, tempmin, tempmax, iend, tmax;
  logic       tc, cc, cv, imonen, vmonen, tmonen, done, timeout, fault;
  logic [2:0] state;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;
  int act    = 0;

  assign outs = {tc, cc, cv, imonen, vmonen, tmonen, done, timeout, fault};

  always #5 clk = ~clk;

  batcharger_ctrl_p #(
    .W(8), .DIV_BITS(2), .TMR_W(8), .VMAX(8'hD6), .VHYST(8'd5)
  ) dut (
    .clk_i(clk), .rstz_i(rstz), .en_i(en), .vtok_i(vtok),
    .vbat_i(vbat), .ibat_i(ibat), .tbat_i(tbat),
    .vcutoff_i(vcutoff), .vpreset_i(vpreset),
    .tempmin_i(tempmin), .tempmax_i(tempmax), .iend_i(iend),
    .tmax_i(tmax),
    .tc_o(tc), .cc_o(cc), .cv_o(cv),
    .imonen_o(imonen), .vmonen_o(vmonen), .tmonen_o(tmonen),
    .done_o(done), .timeout_o(timeout), .fault_o(fault),
    .state_o(state)
  );

  typedef struct {
    logic       en;
    logic       vtok;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic [2:0] st;
    logic [8:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic v, logic [7:0] vb, logic [7:0] ib,
                              logic [7:0] tb, logic [2:0] s, logic [8:0] o);
    vec_t r;
    r.en = e; r.vtok = v; r.vbat = vb; r.ibat = ib; r.tbat = tb; r.st = s; r.o = o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [2:0] s_exp, input logic [8:0] o_exp);
    checks++;
    if (state !== s_exp || outs !== o_exp) begin
      errors++;
      $display("FAIL %s: state=%0d outs=%b required state=%0d outs=%b",
               name, state, outs, s_exp, o_exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock; sample 1 time unit after the rising edge and count cycles
  // spent in a charging state.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (state == 3'd2 || state == 3'd3 || state == 3'd4) act++;
  endtask

  task automatic do_reset();
    #2;
    rstz = 1'b1; en = 1'b0; vtok = 1'b0;
    #1;
    chk("reset_state", 3'd0, O_IDLE);
    @(negedge clk);
    rstz = 1'b0;
    act  = 0;
  endtask

  // Reset, enable and walk WAIT -> TC.
  task automatic start_tc(input logic [7:0] tm);
    do_reset();
    tmax = tm; en = 1'b1; vtok = 1'b1; vbat = 8'd100; ibat = 8'd128; tbat = 8'd100;
    cyc();
    cyc();
    act = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic bad;
    rstz = 1'b1; en = 1'b0; vtok = 1'b0;
    vbat = 8'd100; ibat = 8'd128; tbat = 8'd100;
    vcutoff = 8'd147; vpreset = 8'd188; tempmin = 8'd50; tempmax = 8'd200;
    iend = 8'd2; tmax = 8'd0;

    // ---------------- table-driven sequence (timeout disabled) -------------
    //             en  vtok vbat    ibat    tbat    state  outputs
    tbl.push_back(mk(1, 1, 8'd100, 8'd128, 8'd100, 3'd1, O_WAIT));
    tbl.push_back(mk(1, 1, 8'd100, 8'd128, 8'd100, 3'd2, O_TC));
    tbl.push_back(mk(1, 1, 8'd150, 8'd128, 8'd100, 3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'd190, 8'd128, 8'd100, 3'd4, O_CV));
    tbl.push_back(mk(1, 1, 8'd190, 8'd1,   8'd100, 3'd6, O_DONE));
    tbl.push_back(mk(1, 1, 8'd184, 8'd1,   8'd100, 3'd6, O_DONE));
    tbl.push_back(mk(1, 1, 8'd183, 8'd1,   8'd100, 3'd6, O_DONE));
    tbl.push_back(mk(1, 1, 8'd182, 8'd128, 8'd100, 3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'd182, 8'd128, 8'd220, 3'd5, O_PAUSE));
    tbl.push_back(mk(1, 1, 8'd182, 8'd128, 8'd200, 3'd5, O_PAUSE));
    tbl.push_back(mk(1, 1, 8'd182, 8'd128, 8'd100, 3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'd190, 8'd128, 8'd50,  3'd5, O_PAUSE));
    tbl.push_back(mk(1, 1, 8'd190, 8'd128, 8'd51,  3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'd190, 8'd128, 8'd100, 3'd4, O_CV));
    tbl.push_back(mk(1, 0, 8'd190, 8'd1,   8'd220, 3'd4, O_CV));
    tbl.push_back(mk(1, 1, 8'hD7,  8'd1,   8'd220, 3'd7, O_FAULT));
    tbl.push_back(mk(1, 1, 8'd100, 8'd128, 8'd100, 3'd7, O_FAULT));
    tbl.push_back(mk(0, 1, 8'd100, 8'd128, 8'd100, 3'd0, O_IDLE));
    tbl.push_back(mk(1, 0, 8'd100, 8'd128, 8'd100, 3'd1, O_WAIT));
    tbl.push_back(mk(1, 0, 8'd100, 8'd128, 8'd100, 3'd1, O_WAIT));
    tbl.push_back(mk(1, 1, 8'd140, 8'd128, 8'd100, 3'd2, O_TC));
    tbl.push_back(mk(1, 1, 8'd147, 8'd128, 8'd100, 3'd2, O_TC));
    tbl.push_back(mk(1, 1, 8'd148, 8'd128, 8'd100, 3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'd188, 8'd2,   8'd100, 3'd4, O_CV));
    tbl.push_back(mk(1, 1, 8'd188, 8'd2,   8'd100, 3'd4, O_CV));
    tbl.push_back(mk(1, 1, 8'd188, 8'd1,   8'd100, 3'd6, O_DONE));
    tbl.push_back(mk(1, 1, 8'd140, 8'd1,   8'd100, 3'd2, O_TC));
    tbl.push_back(mk(1, 1, 8'hD6,  8'd1,   8'd100, 3'd3, O_CC));
    tbl.push_back(mk(1, 1, 8'hD6,  8'd1,   8'd100, 3'd4, O_CV));

    do_reset();
    tmax = 8'd0;
    foreach (tbl[i]) begin
      en = tbl[i].en; vtok = tbl[i].vtok;
      vbat = tbl[i].vbat; ibat = tbl[i].ibat; tbat = tbl[i].tbat;
      cyc();
      chk($sformatf("table_row_%0d", i), tbl[i].st, tbl[i].o);
    end

    // ---------------- timeout: 3 ticks x 4 cycles -------------------------
    start_tc(8'd3);
    chk("to_tc_entry", 3'd2, O_TC);
    n = 0;
    while (state != 3'd6 && n < 100) begin
      cyc();
      n++;
    end
    chk_int("to_cycles", n, 12);
    chk("to_done_flag", 3'd6, O_DONE_TO);
    // Recharge from DONE clears the timeout flag and restarts the timer.
    vbat = 8'd140;
    cyc();
    chk("to_recharge_tc", 3'd2, O_TC);
    repeat (11) cyc();
    chk("to_timer_restart", 3'd2, O_TC);
    // Over-voltage on the very edge the timeout would fire wins.
    vbat = 8'hD7;
    cyc();
    chk("to_ov_priority", 3'd7, O_FAULT);
    en = 1'b0;
    cyc();
    chk("to_fault_exit", 3'd0, O_IDLE);

    // ---------------- tmax = 0 holds TC indefinitely ----------------------
    start_tc(8'd0);
    bad = 1'b0;
    repeat (300) begin
      cyc();
      if (state != 3'd2) bad = 1'b1;
    end
    chk_int("tmax0_hold_deviation", int'(bad), 0);
    chk("tmax0_hold", 3'd2, O_TC);

    // ---------------- pause freezes the timer -----------------------------
    // With tmax=10 the charge must last exactly 40 cycles in TC/CC/CV,
    // however long it sits in PAUSE.
    start_tc(8'd10);
    vbat = 8'd150;
    cyc();
    chk("pause_cc", 3'd3, O_CC);
    repeat (5) cyc();
    tbat = 8'd220;
    cyc();
    chk("pause_enter", 3'd5, O_PAUSE);
    repeat (999) cyc();
    chk("pause_hold", 3'd5, O_PAUSE);
    tbat = 8'd100;
    cyc();
    chk("pause_resume_cc", 3'd3, O_CC);
    n = 0;
    while (state != 3'd6 && n < 200) begin
      cyc();
      n++;
    end
    chk_int("pause_active_cycles", act, 40);
    chk("pause_timeout_done", 3'd6, O_DONE_TO);

    // ---------------- asynchronous reset mid-charge -----------------------
    start_tc(8'd0);
    vbat = 8'd150;
    cyc();
    vbat = 8'd190;
    cyc();
    chk("arst_cv", 3'd4, O_CV);
    #2;
    rstz = 1'b1;
    #1;
    chk("arst_immediate", 3'd0, O_IDLE);
    #2;
    rstz = 1'b0;
    en = 1'b1; vtok = 1'b0; vbat = 8'd100; tbat = 8'd100;
    cyc();
    chk("vtok0_wait", 3'd1, O_WAIT);
    repeat (5) cyc();
    chk("vtok0_wait_hold", 3'd1, O_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
